// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, commutator depth, rounding/saturation
// helper and the 8-entry twiddle ROM contents (W16^k, Q1.11).
package fft_pkg;

    localparam int unsigned DATA_W      = 12;
    localparam int unsigned TWID_W      = 12;
    localparam int unsigned COMM_DEPTH  = 2;
    localparam int unsigned TWID_ADDR_W = 3;

    typedef struct packed {
        logic signed [TWID_W-1:0] re;
        logic signed [TWID_W-1:0] im;
    } twiddle_t;

    // Round half-up by 'frac' fractional bits, then clamp to a signed 'w'-bit range.
    function automatic logic signed [63:0] round_sat(logic signed [63:0] acc,
                                                     int unsigned frac, int unsigned w);
        logic signed [63:0] r;
        logic signed [63:0] lim_hi;
        logic signed [63:0] lim_lo;
        r      = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        lim_hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lim_lo = -(64'sd1 <<< (w - 1));
        if (r > lim_hi) begin
            r = lim_hi;
        end else if (r < lim_lo) begin
            r = lim_lo;
        end
        return r;
    endfunction

    // exp(-j*2*pi*k/16); +1.0 is clamped to 2047.
    function automatic twiddle_t tw_rom(logic [TWID_ADDR_W-1:0] k);
        twiddle_t t;
        unique case (k)
            3'd0:    t = '{re:  12'sd2047, im:  12'sd0};
            3'd1:    t = '{re:  12'sd1892, im: -12'sd784};
            3'd2:    t = '{re:  12'sd1448, im: -12'sd1448};
            3'd3:    t = '{re:  12'sd784,  im: -12'sd1892};
            3'd4:    t = '{re:  12'sd0,    im: -12'sd2048};
            3'd5:    t = '{re: -12'sd784,  im: -12'sd1892};
            3'd6:    t = '{re: -12'sd1448, im: -12'sd1448};
            default: t = '{re: -12'sd1892, im: -12'sd784};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/delay_commutator.sv
// MDC re-commutator: DEPTH-deep delay on the lower line, swap mux, then a
// DEPTH-deep delay on the upper output. Complex samples travel packed {re, im}.
module delay_commutator #(
    parameter int unsigned width = 12,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [2*width-1:0] up_in,
    input  logic [2*width-1:0] lo_in,
    output logic [2*width-1:0] up_out,
    output logic [2*width-1:0] lo_out
);

    localparam int unsigned SEL_BIT = $clog2(DEPTH);
    localparam int unsigned CW      = SEL_BIT + 1;

    logic [CW-1:0]      cnt_q;
    logic [2*width-1:0] lo_dly_q [DEPTH];
    logic [2*width-1:0] up_dly_q [DEPTH];
    logic [2*width-1:0] mux_up;
    logic               sel;

    assign sel = cnt_q[SEL_BIT];

    always_comb begin
        mux_up = up_in;
        lo_out = lo_dly_q[DEPTH-1];
        if (sel) begin
            mux_up = lo_dly_q[DEPTH-1];
            lo_out = up_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lo_dly_q[i] <= '0;
                up_dly_q[i] <= '0;
            end
        end else if (en) begin
            cnt_q       <= cnt_q + CW'(1);
            lo_dly_q[0] <= lo_in;
            up_dly_q[0] <= mux_up;
            for (int i = 1; i < DEPTH; i++) begin
                lo_dly_q[i] <= lo_dly_q[i-1];
                up_dly_q[i] <= up_dly_q[i-1];
            end
        end
    end

    assign up_out = up_dly_q[DEPTH-1];

endmodule

// File: rtl/bfly_comm_stage.sv
// Radix-2 MDC stage after stage0: DIF butterfly, twiddle multiply with
// round/saturate, then re-commutation into the two-line format.
module bfly_comm_stage
    import fft_pkg::*;
#(
    parameter int unsigned width     = DATA_W,
    parameter int unsigned TW_W      = TWID_W,
    parameter int unsigned DEPTH     = COMM_DEPTH,
    parameter int unsigned TW_ADDR_W = TWID_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [width-1:0] line1_re,
    input  logic signed [width-1:0] line1_im,
    input  logic signed [width-1:0] line2_re,
    input  logic signed [width-1:0] line2_im,
    output logic [TW_ADDR_W-1:0]    tw_addr,
    input  logic signed [TW_W-1:0]  tw_re,
    input  logic signed [TW_W-1:0]  tw_im,
    output logic                    out_valid,
    output logic signed [width-1:0] line1_out_re,
    output logic signed [width-1:0] line1_out_im,
    output logic signed [width-1:0] line2_out_re,
    output logic signed [width-1:0] line2_out_im
);

    localparam int unsigned XW          = width + 1;
    localparam int unsigned PW          = width + TW_W + 1;
    localparam int unsigned PRIME_BEATS = 2 + 2 * DEPTH;
    localparam int unsigned PCW         = $clog2(PRIME_BEATS + 1);

    logic signed [width-1:0] s1_sum_re_d, s1_sum_im_d, s1_dif_re_d, s1_dif_im_d;
    logic signed [width-1:0] s1_sum_re_q, s1_sum_im_q, s1_dif_re_q, s1_dif_im_q;
    logic signed [width-1:0] s2_lo_re_d, s2_lo_im_d;
    logic signed [width-1:0] s2_up_re_q, s2_up_im_q, s2_lo_re_q, s2_lo_im_q;
    logic signed [PW-1:0]    dr_x, di_x, wr_x, wi_x, prod_re, prod_im;
    logic [TW_ADDR_W-1:0]    tw_addr_q;
    logic [PCW-1:0]          prime_cnt_q;
    logic [2*width-1:0]      comm_up_out, comm_lo_out;

    // One guard bit makes the halved sum/difference exact before truncation.
    always_comb begin
        s1_sum_re_d = width'((XW'(line1_re) + XW'(line2_re)) >>> 1);
        s1_sum_im_d = width'((XW'(line1_im) + XW'(line2_im)) >>> 1);
        s1_dif_re_d = width'((XW'(line1_re) - XW'(line2_re)) >>> 1);
        s1_dif_im_d = width'((XW'(line1_im) - XW'(line2_im)) >>> 1);
    end

    // tw_re/tw_im belong to the beat held in S1 (address issued as it was accepted).
    always_comb begin
        dr_x       = PW'(s1_dif_re_q);
        di_x       = PW'(s1_dif_im_q);
        wr_x       = PW'(tw_re);
        wi_x       = PW'(tw_im);
        prod_re    = dr_x * wr_x - di_x * wi_x;
        prod_im    = dr_x * wi_x + di_x * wr_x;
        s2_lo_re_d = width'(round_sat(64'(prod_re), TW_W - 1, width));
        s2_lo_im_d = width'(round_sat(64'(prod_im), TW_W - 1, width));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum_re_q <= '0;
            s1_sum_im_q <= '0;
            s1_dif_re_q <= '0;
            s1_dif_im_q <= '0;
            s2_up_re_q  <= '0;
            s2_up_im_q  <= '0;
            s2_lo_re_q  <= '0;
            s2_lo_im_q  <= '0;
            tw_addr_q   <= '0;
            prime_cnt_q <= '0;
        end else if (in_valid) begin
            s1_sum_re_q <= s1_sum_re_d;
            s1_sum_im_q <= s1_sum_im_d;
            s1_dif_re_q <= s1_dif_re_d;
            s1_dif_im_q <= s1_dif_im_d;
            s2_up_re_q  <= s1_sum_re_q;
            s2_up_im_q  <= s1_sum_im_q;
            s2_lo_re_q  <= s2_lo_re_d;
            s2_lo_im_q  <= s2_lo_im_d;
            tw_addr_q   <= tw_addr_q + TW_ADDR_W'(1);
            if (prime_cnt_q != PCW'(PRIME_BEATS)) begin
                prime_cnt_q <= prime_cnt_q + PCW'(1);
            end
        end
    end

    delay_commutator #(
        .width (width),
        .DEPTH (DEPTH)
    ) u_comm (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_valid),
        .up_in  ({s2_up_re_q, s2_up_im_q}),
        .lo_in  ({s2_lo_re_q, s2_lo_im_q}),
        .up_out (comm_up_out),
        .lo_out (comm_lo_out)
    );

    assign tw_addr                      = tw_addr_q;
    assign out_valid                    = in_valid & (prime_cnt_q == PCW'(PRIME_BEATS));
    assign {line1_out_re, line1_out_im} = comm_up_out;
    assign {line2_out_re, line2_out_im} = comm_lo_out;

endmodule

// File: tb/tb_bfly_comm_stage.sv
// Bench for bfly_comm_stage: scenario tasks with a queue scoreboard fed at drive
// time and drained whenever out_valid is observed.
module tb_bfly_comm_stage;

    localparam int W     = 12;
    localparam int TWW   = 12;
    localparam int D     = 2;
    localparam int AW    = 3;
    localparam int PRIME = 2 + 2 * D;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic signed [W-1:0]   line1_re = '0, line1_im = '0, line2_re = '0, line2_im = '0;
    logic [AW-1:0]         tw_addr;
    logic signed [TWW-1:0] tw_re, tw_im;
    logic                  out_valid;
    logic signed [W-1:0]   line1_out_re, line1_out_im, line2_out_re, line2_out_im;

    logic signed [TWW-1:0] rom_re [8];
    logic signed [TWW-1:0] rom_im [8];

    typedef struct {
        int l1re;
        int l1im;
        int l2re;
        int l2im;
    } exp_t;

    exp_t sbq[$];
    exp_t ex [64];
    int   ar [64], ai [64], br [64], bi [64];
    int   ur [64], ui [64], lr [64], li [64];
    int   n_cmp  = 0;
    int   n_fail = 0;

    bfly_comm_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .line1_re     (line1_re),
        .line1_im     (line1_im),
        .line2_re     (line2_re),
        .line2_im     (line2_im),
        .tw_addr      (tw_addr),
        .tw_re        (tw_re),
        .tw_im        (tw_im),
        .out_valid    (out_valid),
        .line1_out_re (line1_out_re),
        .line1_out_im (line1_out_im),
        .line2_out_re (line2_out_re),
        .line2_out_im (line2_out_im)
    );

    always #5 clk = ~clk;

    // Synchronous twiddle ROM: one clock of read latency.
    always @(posedge clk) begin
        tw_re <= rom_re[tw_addr];
        tw_im <= rom_im[tw_addr];
    end

    function automatic int rnd_sat(longint p);
        longint r;
        r = (p + (longint'(1) <<< (TWW - 2))) >>> (TWW - 1);
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return int'(r);
    endfunction

    task automatic set_rom(input int wr, input int wi);
        for (int k = 0; k < 8; k++) begin
            rom_re[k] = TWW'(wr);
            rom_im[k] = TWW'(wi);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
    endtask

    task automatic gen_ramp(input int n);
        for (int t = 0; t < n; t++) begin
            ar[t] = 8 * t - 50;
            ai[t] = 3 - 5 * t;
            br[t] = 7 - 3 * t;
            bi[t] = 2 * t + 11;
        end
    endtask

    // Golden MDC model: butterfly per beat, then output at accepted-beat index t
    // from S2 beat t-2, lower delay of D beats, swap when (t/D) is odd, upper delay D.
    task automatic build_model(input int n, input int wr, input int wi);
        int dr, di, k, sel_t, sel_k;
        for (int s = 0; s < n; s++) begin
            ur[s] = (ar[s] + br[s]) >>> 1;
            ui[s] = (ai[s] + bi[s]) >>> 1;
            dr    = (ar[s] - br[s]) >>> 1;
            di    = (ai[s] - bi[s]) >>> 1;
            lr[s] = rnd_sat(longint'(dr) * wr - longint'(di) * wi);
            li[s] = rnd_sat(longint'(dr) * wi + longint'(di) * wr);
        end
        for (int t = PRIME; t < n; t++) begin
            k     = t - D;
            sel_t = (t / D) % 2;
            sel_k = (k / D) % 2;
            ex[t].l2re = sel_t ? ur[t-2] : lr[t-2-D];
            ex[t].l2im = sel_t ? ui[t-2] : li[t-2-D];
            ex[t].l1re = sel_k ? lr[k-2-D] : ur[k-2];
            ex[t].l1im = sel_k ? li[k-2-D] : ui[k-2];
        end
    endtask

    task automatic test_reset();
        logic signed [31:0] obs [6];
        string names [6] = '{"out_valid", "tw_addr", "l1_re", "l1_im", "l2_re", "l2_im"};
        set_rom(2047, 0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        line1_re = W'($urandom); line1_im = W'($urandom);
        line2_re = W'($urandom); line2_im = W'($urandom);
        repeat (3) @(negedge clk);
        for (int phase = 0; phase < 2; phase++) begin
            #1;
            obs = '{32'(out_valid), 32'(tw_addr), 32'(line1_out_re), 32'(line1_out_im),
                    32'(line2_out_re), 32'(line2_out_im)};
            foreach (obs[i]) begin
                n_cmp++;
                if (obs[i] !== 0) begin
                    n_fail++;
                    $display("FAIL reset%0d %s got %0d want 0", phase, names[i], obs[i]);
                end
            end
            @(negedge clk);
            rst_n    = 1'b1;
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // Identical beats: after priming both output lines carry U when (t/D) is odd, else L.
    task automatic test_const(input string tag, input int a_re, input int a_im, input int b_re,
                              input int b_im, input int w_re, input int w_im, input int u_re,
                              input int u_im, input int l_re, input int l_im);
        exp_t e;
        set_rom(w_re, w_im);
        apply_reset();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            line1_re = W'(a_re); line1_im = W'(a_im);
            line2_re = W'(b_re); line2_im = W'(b_im);
            #1;
            if (t >= PRIME) begin
                e = ((t / D) % 2 == 1) ? '{u_re, u_im, u_re, u_im} : '{l_re, l_im, l_re, l_im};
                sbq.push_back(e);
            end
            n_cmp++;
            if (out_valid !== (t >= PRIME)) begin
                n_fail++;
                $display("FAIL %s out_valid beat %0d got %b want %b", tag, t, out_valid, t >= PRIME);
            end
            if (out_valid === 1'b1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (32'(line1_out_re) !== e.l1re || 32'(line1_out_im) !== e.l1im ||
                    32'(line2_out_re) !== e.l2re || 32'(line2_out_im) !== e.l2im) begin
                    n_fail++;
                    $display("FAIL %s data beat %0d got (%0d,%0d)/(%0d,%0d) want (%0d,%0d)/(%0d,%0d)",
                             tag, t, line1_out_re, line1_out_im, line2_out_re, line2_out_im,
                             e.l1re, e.l1im, e.l2re, e.l2im);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover got %0d want 0", tag, sbq.size());
        end
    endtask

    task automatic test_ramp_stream(input string tag, input int n, input int gap_pct,
                                    input bit do_reset);
        exp_t e;
        set_rom(2047, 0);
        if (do_reset) apply_reset();
        gen_ramp(n);
        build_model(n, 2047, 0);
        for (int t = 0; t < n; t++) begin
            for (int g = 0; g < 3 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                line1_re = W'($urandom); line2_im = W'($urandom);
                #1;
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s gap before beat %0d out_valid got %b want 0", tag, t, out_valid);
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            line1_re = W'(ar[t]); line1_im = W'(ai[t]);
            line2_re = W'(br[t]); line2_im = W'(bi[t]);
            #1;
            if (t >= PRIME) sbq.push_back(ex[t]);
            n_cmp++;
            if (tw_addr !== AW'(t % (1 << AW))) begin
                n_fail++;
                $display("FAIL %s tw_addr beat %0d got %0d want %0d", tag, t, tw_addr, t % 8);
            end
            n_cmp++;
            if (out_valid !== (t >= PRIME)) begin
                n_fail++;
                $display("FAIL %s out_valid beat %0d got %b want %b", tag, t, out_valid, t >= PRIME);
            end
            if (out_valid === 1'b1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (32'(line1_out_re) !== e.l1re || 32'(line1_out_im) !== e.l1im ||
                    32'(line2_out_re) !== e.l2re || 32'(line2_out_im) !== e.l2im) begin
                    n_fail++;
                    $display("FAIL %s data beat %0d got (%0d,%0d)/(%0d,%0d) want (%0d,%0d)/(%0d,%0d)",
                             tag, t, line1_out_re, line1_out_im, line2_out_re, line2_out_im,
                             e.l1re, e.l1im, e.l2re, e.l2im);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover got %0d want 0", tag, sbq.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic signed [31:0] obs [6];
        string names [6] = '{"out_valid", "tw_addr", "l1_re", "l1_im", "l2_re", "l2_im"};
        set_rom(2047, 0);
        apply_reset();
        gen_ramp(8);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            line1_re = W'(ar[t]); line1_im = W'(ai[t]);
            line2_re = W'(br[t]); line2_im = W'(bi[t]);
        end
        #1;
        n_cmp++;
        if (tw_addr !== AW'(5)) begin
            n_fail++;
            $display("FAIL midreset pre tw_addr got %0d want 5", tw_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        obs = '{32'(out_valid), 32'(tw_addr), 32'(line1_out_re), 32'(line1_out_im),
                32'(line2_out_re), 32'(line2_out_im)};
        foreach (obs[i]) begin
            n_cmp++;
            if (obs[i] !== 0) begin
                n_fail++;
                $display("FAIL midreset %s got %0d want 0", names[i], obs[i]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_ramp_stream("restart", 8, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_const("basic", 100, 0, 20, 0, 2047, 0, 60, 0, 40, 0);
        test_const("rot_nj", 74, -10, 0, 0, 0, -2048, 37, -5, -5, -37);
        test_const("sat_neg", 2047, 2047, -2048, -2048, -2048, -2048, -1, -1, 0, -2048);
        test_const("sat_pos", -2048, -2048, 2047, 2047, -2048, -2048, -1, -1, 0, 2047);
        test_ramp_stream("ramp", 16, 0, 1'b1);
        test_ramp_stream("gaps", 16, 35, 1'b1);
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
